// File: rtl/mem_stage_pkg.sv
// Shared instruction codes and decode groupings for the memory stage.
// Also holds the misalignment rule used when MEM_STAGE_MISALIGN_TRAP_EN is defined.
package mem_stage_pkg;

  localparam logic [5:0] i_nop  = 6'd0;
  localparam logic [5:0] i_add  = 6'd1;
  localparam logic [5:0] i_addi = 6'd2;
  localparam logic [5:0] i_sub  = 6'd3;
  localparam logic [5:0] i_lui  = 6'd4;
  localparam logic [5:0] i_beq  = 6'd8;
  localparam logic [5:0] i_bne  = 6'd9;
  localparam logic [5:0] i_blt  = 6'd10;
  localparam logic [5:0] i_bge  = 6'd11;
  localparam logic [5:0] i_bltu = 6'd12;
  localparam logic [5:0] i_bgeu = 6'd13;
  localparam logic [5:0] i_lb   = 6'd16;
  localparam logic [5:0] i_lh   = 6'd17;
  localparam logic [5:0] i_lw   = 6'd18;
  localparam logic [5:0] i_lbu  = 6'd19;
  localparam logic [5:0] i_lhu  = 6'd20;
  localparam logic [5:0] i_sb   = 6'd24;
  localparam logic [5:0] i_sh   = 6'd25;
  localparam logic [5:0] i_sw   = 6'd26;

  function automatic logic is_load(input logic [5:0] code);
    return (code == i_lb) || (code == i_lh) || (code == i_lw) ||
           (code == i_lbu) || (code == i_lhu);
  endfunction

  function automatic logic is_store(input logic [5:0] code);
    return (code == i_sb) || (code == i_sh) || (code == i_sw);
  endfunction

  function automatic logic is_branch(input logic [5:0] code);
    return (code == i_beq) || (code == i_bne) || (code == i_blt) ||
           (code == i_bge) || (code == i_bltu) || (code == i_bgeu);
  endfunction

  function automatic logic is_half(input logic [5:0] code);
    return (code == i_lh) || (code == i_lhu) || (code == i_sh);
  endfunction

  function automatic logic is_word(input logic [5:0] code);
    return (code == i_lw) || (code == i_sw);
  endfunction

  function automatic logic is_misaligned(input logic [5:0] code, input logic [1:0] addr);
    return (is_half(code) && addr[0]) || (is_word(code) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational byte-lane unit: extracts and extends load data, and builds
// replicated store data with byte strobes from the same offset logic.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [1:0]  offset,
  input  logic [5:0]  code,
  output logic [31:0] ext_data,
  output logic [31:0] lane_data,
  output logic [3:0]  lane_strb
);

  logic [1:0]  eff;
  logic [31:0] shifted;

  // Offset bits that would misalign are dropped, so halves use addr[1] and words ignore both.
  always_comb begin
    eff = offset;
    if (is_half(code)) begin
      eff = {offset[1], 1'b0};
    end else if (is_word(code)) begin
      eff = 2'b00;
    end
    shifted   = data_in >> {eff, 3'b000};
    ext_data  = shifted;
    lane_data = data_in;
    lane_strb = 4'b0000;
    case (code)
      i_lb:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
      i_lbu: ext_data = {24'h000000, shifted[7:0]};
      i_lh:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
      i_lhu: ext_data = {16'h0000, shifted[15:0]};
      i_sb: begin
        lane_data = {4{data_in[7:0]}};
        lane_strb = 4'b0001 << eff;
      end
      i_sh: begin
        lane_data = {2{data_in[15:0]}};
        lane_strb = 4'b0011 << eff;
      end
      i_sw:    lane_strb = 4'b1111;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: pass-through to writeback or a req/gnt/rvalid memory transaction.
// Define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned accesses instead of masking the address.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [5:0]       instr_in,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] store_data,
  input  logic [4:0]       rd_in,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             wb_valid,
  output logic             wb_we,
  output logic [WIDTH-1:0] wb_data,
  output logic [4:0]       wb_rd,
  output logic             misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, next_state;
  logic        accept, mem_op, misal;
  logic [1:0]  off_q;
  logic [5:0]  code_q;
  logic [4:0]  rd_q;
  logic [31:0] al_data;
  logic [1:0]  al_offset;
  logic [5:0]  al_code;
  logic [31:0] al_ext, al_lane_data;
  logic [3:0]  al_lane_strb;

  assign accept = valid_in && ready_in;
  assign mem_op = is_load(instr_in) || is_store(instr_in);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misal = is_misaligned(instr_in, alu_out[1:0]);
`else
  assign misal = 1'b0;
`endif

  // One lane unit serves both directions: store steering while idle, load extraction otherwise.
  assign al_data   = (state == IDLE) ? store_data : mem_rdata;
  assign al_offset = (state == IDLE) ? alu_out[1:0] : off_q;
  assign al_code   = (state == IDLE) ? instr_in : code_q;

  mem_load_align u_align (
    .data_in   (al_data),
    .offset    (al_offset),
    .code      (al_code),
    .ext_data  (al_ext),
    .lane_data (al_lane_data),
    .lane_strb (al_lane_strb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ready_in   = 1'b0;
    mem_req    = 1'b0;
    case (state)
      IDLE: begin
        ready_in = 1'b1;
        if (accept && mem_op && !misal) next_state = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) next_state = mem_we ? IDLE : WAIT;
      end
      WAIT: begin
        if (mem_rvalid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request fields are captured once on accept so they stay stable across REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      off_q     <= '0;
      code_q    <= '0;
      rd_q      <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_data   <= '0;
      wb_rd     <= '0;
      misalign  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (mem_op && !misal) begin
              mem_we    <= is_store(instr_in);
              mem_addr  <= {alu_out[31:2], 2'b00};
              mem_wdata <= al_lane_data;
              mem_wstrb <= al_lane_strb;
              off_q     <= alu_out[1:0];
              code_q    <= instr_in;
              rd_q      <= rd_in;
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= !is_branch(instr_in) && !misal;
              wb_data  <= alu_out;
              wb_rd    <= rd_in;
              misalign <= misal;
            end
          end
        end
        REQ: begin
          if (mem_gnt && mem_we) begin
            wb_valid <= 1'b1;
            wb_we    <= 1'b0;
            wb_rd    <= rd_q;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            wb_valid <= 1'b1;
            wb_we    <= 1'b1;
            wb_data  <= al_ext;
            wb_rd    <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
